// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-back write-allocate data cache with halt flush
//   Optional hit counter written to HIT_ADDR after flush: define DCACHE_HIT_COUNT_EN
//   Ports:
//     CLK, nRST                  clock (rising edge), async active-low reset
//     dmemREN/dmemWEN/dmemaddr/dmemstore  datapath request
//     halt                       start flushing dirty lines
//     dhit/dmemload              request completes / load data
//     flushed                    flush complete, sticky until reset
//     dREN/dWEN/daddr/dstore     memory request
//     dload/dwait                memory read data / busy
module dcache_dm #(
  parameter int          SETS     = 16,
  parameter logic [31:0] HIT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  typedef enum logic [2:0] {
    IDLE, WB, FETCH, FLUSH, DONE
`ifdef DCACHE_HIT_COUNT_EN
    , CNT
`endif
  } state_t;
  state_t state_q, state_d;
  logic [IW-1:0] fi_q, fi_d;
  logic [SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag_q [SETS];
  logic [31:0] data_q [SETS];
  logic [IW-1:0] idx;
  logic [TW-1:0] rtag;
  logic req, hit, fdirty, unused_ok;
  assign idx = dmemaddr[IW+1:2];
  assign rtag = dmemaddr[31:IW+2];
  assign req = dmemREN | dmemWEN;
  assign hit = state_q == IDLE && valid_q[idx] && tag_q[idx] == rtag && req && !halt;
  assign fdirty = valid_q[fi_q] & dirty_q[fi_q];
  assign unused_ok = ^{dmemaddr[1:0], HIT_ADDR};
`ifdef DCACHE_HIT_COUNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt_q <= '0;
    else if (hit && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
`endif
  always_comb begin
    state_d = state_q;
    fi_d = fi_q;
    dhit = 1'b0;
    dmemload = '0;
    flushed = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    case (state_q)
      IDLE: begin
        dhit = hit;
        dmemload = hit && dmemREN ? data_q[idx] : '0;
        // halt wins over any pending request
        if (halt) state_d = FLUSH;
        else if (req && !hit) state_d = valid_q[idx] && dirty_q[idx] ? WB : FETCH;
      end
      WB: begin
        dWEN = 1'b1;
        daddr = {tag_q[idx], idx, 2'b00};
        dstore = data_q[idx];
        if (!dwait) state_d = FETCH;
      end
      FETCH: begin
        dREN = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) state_d = IDLE;
      end
      FLUSH: begin
        dWEN = fdirty;
        daddr = fdirty ? {tag_q[fi_q], fi_q, 2'b00} : '0;
        dstore = fdirty ? data_q[fi_q] : '0;
        if (!fdirty || !dwait) begin
          fi_d = fi_q + 1'b1;
          // leaving FLUSH on the last line keeps the wrapped counter from rescanning
`ifdef DCACHE_HIT_COUNT_EN
          if (&fi_q) state_d = CNT;
`else
          if (&fi_q) state_d = DONE;
`endif
        end
      end
`ifdef DCACHE_HIT_COUNT_EN
      CNT: begin
        dWEN = 1'b1;
        daddr = HIT_ADDR;
        dstore = cnt_q;
        if (!dwait) state_d = DONE;
      end
`endif
      DONE: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      fi_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      fi_q <= fi_d;
      if (hit && dmemWEN) dirty_q[idx] <= 1'b1;
      if (state_q == WB && !dwait) dirty_q[idx] <= 1'b0;
      if (state_q == FETCH && !dwait) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (state_q == FLUSH && fdirty && !dwait) dirty_q[fi_q] <= 1'b0;
    end
  // line contents need no reset; valid bits gate their use
  always_ff @(posedge CLK) begin
    if (hit && dmemWEN) data_q[idx] <= dmemstore;
    if (state_q == FETCH && !dwait) begin
      data_q[idx] <= dload;
      tag_q[idx] <= rtag;
    end
  end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed scoreboard bench for dcache_dm (SETS=16, memory latency 2)
module tb_dcache_dm;
  localparam int LAT = 2;
  logic CLK = 1'b0, nRST = 1'b0;
  logic dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0, dload = '0;
  logic dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore;
  int n = 0, fails = 0;
  int wcnt = 0;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d;} xfer_t;
  xfer_t exp_q[$];
  dcache_dm #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );
  always #5 CLK = ~CLK;
  // memory: each transfer is busy LAT cycles, then completes
  assign dwait = wcnt != LAT;
  always @(posedge CLK or negedge nRST)
    if (!nRST) wcnt <= 0;
    else wcnt <= ((dREN | dWEN) && wcnt != LAT) ? wcnt + 1 : 0;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // scoreboard: every completed memory transfer pops the next expected one
  always @(negedge CLK)
    if (nRST && (dREN | dWEN) && !dwait) begin
      xfer_t e;
      e = exp_q.size() != 0 ? exp_q.pop_front() : '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      check("mem_xfer", {31'b0, dWEN, daddr, dWEN ? dstore : 32'h0}, {31'b0, e.w, e.a, e.d});
    end
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    xfer_t e;
    e.w = w; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input int lat);
    int c = 0;
    dmemREN = !w; dmemWEN = w; dmemaddr = a; dmemstore = d;
    @(negedge CLK);
    while (!dhit && c < 50) begin
      c++;
      @(negedge CLK);
    end
    check({tag, "_lat"}, 96'(c), 96'(lat));
    if (!w) check({tag, "_load"}, 96'(dmemload), 96'(exp));
    @(posedge CLK);
    #1 dmemREN = 1'b0; dmemWEN = 1'b0;
    check({tag, "_sb_empty"}, 96'(exp_q.size()), 96'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (2) @(negedge CLK);
    check("rst_ctl", {92'b0, dhit, dREN, dWEN, flushed}, 96'b0);
    check("rst_data", {daddr, dstore, dmemload}, 96'b0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    dload = 32'hDEADBEEF;
    push(1'b0, 32'h40, 32'h0);
    access("cold_miss", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1 + LAT + 1);
    access("wr_hit", 1'b1, 32'h40, 32'h12345678, 32'h0, 0);
    access("rd_hit", 1'b0, 32'h40, 32'h0, 32'h12345678, 0);
    dload = 32'hCAFEF00D;
    push(1'b1, 32'h40, 32'h12345678);
    push(1'b0, 32'h440, 32'h0);
    access("evict", 1'b0, 32'h440, 32'h0, 32'hCAFEF00D, 1 + 2 * (LAT + 1));
    access("wr_idx0", 1'b1, 32'h440, 32'hA0, 32'h0, 0);
    push(1'b0, 32'h14, 32'h0);
    access("wr_idx5", 1'b1, 32'h14, 32'hA5, 32'h0, 1 + LAT + 1);
    push(1'b0, 32'h3C, 32'h0);
    access("wr_idx15", 1'b1, 32'h3C, 32'hAF, 32'h0, 1 + LAT + 1);
    push(1'b0, 32'h0C, 32'h0);
    access("rd_idx3", 1'b0, 32'h0C, 32'h0, 32'hCAFEF00D, 1 + LAT + 1);
    push(1'b1, 32'h440, 32'hA0);
    push(1'b1, 32'h14, 32'hA5);
    push(1'b1, 32'h3C, 32'hAF);
    dmemREN = 1'b1; dmemaddr = 32'h440; halt = 1'b1;
    @(negedge CLK);
    check("halt_no_hit", {94'b0, dhit, dWEN}, 96'b0);
    c = 0;
    while (!flushed && c < 200) begin
      c++;
      @(negedge CLK);
    end
    // 3 dirty lines x (LAT+1) + 13 clean lines + the halt cycle
    check("flush_cycles", 96'(c), 96'(1 + 3 * (LAT + 1) + 13));
    check("flush_sb_empty", 96'(exp_q.size()), 96'(0));
    repeat (20) @(negedge CLK);
    check("flushed_held", {92'b0, flushed, dhit, dREN, dWEN}, {92'b0, 4'b1000});
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst2_flushed", 96'(flushed), 96'(0));
    @(posedge CLK);
    #1 nRST = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h80;
    c = 0;
    @(negedge CLK);
    while (!dREN && c < 10) begin
      c++;
      @(negedge CLK);
    end
    check("fetch_start", 96'(dREN), 96'(1));
    nRST = 1'b0;
    #1 check("rst_mid_fetch", {94'b0, dREN, dWEN}, 96'b0);
    dmemREN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    dload = 32'h11110080;
    push(1'b0, 32'h80, 32'h0);
    access("miss_after_rst", 1'b0, 32'h80, 32'h0, 32'h11110080, 1 + LAT + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
